regbank_shadow: RTL and testbench
=================================

// Module: regbank_shadow
// PURPOSE
//  Parametrised successor to the fixed 14-register PLL control file. Provides
//  N-register x W-bit control storage behind a 4-phase req/ack bus.
//  Adds per-register double-buffering (shadow -> active on commit), a write lock,
//  and error reporting. Sits between the serial-interface slave and the analog/DPLL control nets.
// PARAMETERS
//  REG_COUNT   16        number of data registers, addresses 0..REG_COUNT-1 (<= 2**ADDR_W-1)
//  DATA_W      8         register width
//  ADDR_W      8         address width
//  RST_VAL     all 0     packed REG_COUNT*DATA_W; reset value of shadow and active copies
//  RD_MASK     all 1     packed REG_COUNT*DATA_W; 0 bits read back as 0 (storage is kept)
//  SHADOW_MASK all 0     REG_COUNT bits; 1 = register updates its active copy only on commit
//  CTRL_ADDR   all 1s    ADDR_W; address of the control register, outside the data range
// PORTS
//  sclk        in   1                 clock, rising edge
//  rstn        in   1                 reset, asynchronous, active-low
//  req         in   1                 access request, held until ack seen high
//  wre         in   1                 1 = write, 0 = read; sampled with req
//  addr        in   ADDR_W            register address; sampled with req
//  din         in   DATA_W            write data; sampled with req
//  ack         out  1                 access done; high until req drops
//  dout        out  DATA_W            read data; valid while ack = 1, else 0
//  err         out  1                 access error; valid while ack = 1, else 0
//  regs_q      out  REG_COUNT*DATA_W  active register values; reg i = [i*DATA_W +: DATA_W]
//  commit_p    out  1                 one-cycle pulse on the cycle the active copies update
// BEHAVIOUR
//  Reset: FSM=IDLE; ack, dout, err, commit_p = 0; shadow = active = RST_VAL; lock = 0.
//  Reset may assert mid-access. All state returns to reset values immediately.
//  FSM IDLE: req=1 -> latch wre/addr/din, execute access at this edge, go RESP.
//  FSM RESP: ack=1, dout/err held. req=0 -> go IDLE, ack=0 next cycle.
//  Back-to-back: a new req is accepted only from IDLE, so one bubble cycle minimum.
//  Latency: ack rises 1 cycle after req is sampled high.
//  Write, data addr i, lock=0: shadow[i] <= din.
//   If SHADOW_MASK[i]=0, active[i] <= din at the same edge.
//  Write, data addr, lock=1: no update; err=1.
//  Read, data addr i: dout = shadow[i] & RD_MASK[i].
//   Shadowed regs therefore read the pending value.
//  Any other addr (not data, not CTRL_ADDR): no update; dout=0; err=1.
//  Ctrl register at CTRL_ADDR is always writable, regardless of lock.
//   bit0 commit: self-clearing, reads 0.
//   bit1 lock:   read/write.
//   bit2 par_err: read-only, sticky; see CONFIGURATION.
//   Other bits read 0.
//  Commit (ctrl write with bit0=1): active[i] <= shadow[i] for all SHADOW_MASK[i]=1.
//   commit_p=1 for exactly the cycle following the write edge.
//  Ctrl write with bit0=1 and bit1=1: commit applies AND lock is set at the same edge.
//  regs_q is active-copy only; never masked by RD_MASK.
// CONFIGURATION
//  REG_PARITY_EN defined: one even-parity flop per data register, written with shadow.
//   Shadow parity is continuously checked.
//   A mismatch sets par_err (ctrl bit2) at the next edge; par_err clears only on rstn.
//   Reading the register with the mismatch also returns err=1.
//  REG_PARITY_EN undefined: no parity storage; ctrl bit2 reads 0; no parity err.
// TESTING
//  Reset with RST_VAL reg0=8'h5A -> regs_q[7:0]=8'h5A, ack=0, ctrl reads 8'h00.
//  Write reg3=8'hC3 (SHADOW_MASK[3]=0), req held 3 cycles
//   -> ack high from cycle 2 until req drops; regs_q reg3=C3; read -> C3, err=0.
//  SHADOW_MASK[2]=1: write reg2=8'h7E -> regs_q unchanged, read reg2=7E
//   -> write ctrl 8'h01: commit_p 1 cycle, regs_q reg2=7E.
//  Write ctrl 8'h03 -> commit + lock; write reg3=8'h11 -> err=1, reg3 stays C3
//   -> write ctrl 8'h00 -> write reg3=8'h11 succeeds.
//  Read addr REG_COUNT and 8'hF0 -> dout=0, err=1; RD_MASK reg0=8'h0F
//   after write 8'hFF -> reads 8'h0F, regs_q 8'hFF.
//  rstn pulsed during RESP -> ack=0 immediately, all regs back to RST_VAL.
//   With REG_PARITY_EN: force flip shadow bit -> ctrl bit2=1, read of that reg gives err=1.

Source files
------------

// File: rtl/regbank_shadow.sv
// regbank_shadow: N x W control register file behind a 4-phase req/ack bus.
// Per-register shadow/active double-buffering, commit pulse, write lock
// and error reporting. Optional feature macro: REG_PARITY_EN (per-register
// even parity on the shadow copies, sticky par_err in ctrl bit2).
// Ports:
//   sclk, rstn        clock (rising), async active-low reset
//   req, wre          access request (4-phase), 1 = write
//   addr, din         address and write data, sampled with req
//   ack, dout, err    response; dout/err valid while ack = 1, else 0
//   regs_q            active copies, reg i = [i*DATA_W +: DATA_W]
//   commit_p          one-cycle pulse when shadowed active copies update
module regbank_shadow #(
   parameter int                            REG_COUNT   = 16,
   parameter int                            DATA_W      = 8,
   parameter int                            ADDR_W      = 8,
   parameter logic [REG_COUNT*DATA_W-1:0]   RST_VAL     = '0,
   parameter logic [REG_COUNT*DATA_W-1:0]   RD_MASK     = '1,
   parameter logic [REG_COUNT-1:0]          SHADOW_MASK = '0,
   parameter logic [ADDR_W-1:0]             CTRL_ADDR   = '1
) (
   input  logic                          sclk,
   input  logic                          rstn,
   input  logic                          req,
   input  logic                          wre,
   input  logic [ADDR_W-1:0]             addr,
   input  logic [DATA_W-1:0]             din,
   output logic                          ack,
   output logic [DATA_W-1:0]             dout,
   output logic                          err,
   output logic [REG_COUNT*DATA_W-1:0]   regs_q,
   output logic                          commit_p
);

   localparam int TOT_W = REG_COUNT * DATA_W;
   localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
   localparam logic [ADDR_W-1:0] NREG_A = ADDR_W'(REG_COUNT);

   typedef enum logic {
      IDLE,
      RESP
   } state_t;

   state_t              state_q, state_d;
   logic                ack_q, ack_d;
   logic [DATA_W-1:0]   dout_q, dout_d;
   logic                err_q, err_d;
   logic                commit_q, commit_d;
   logic                lock_q, lock_d;
   logic [TOT_W-1:0]    shadow_q, shadow_d;
   logic [TOT_W-1:0]    active_q, active_d;

   logic                is_data;
   logic                is_ctrl;
   logic [IDX_W-1:0]    idx;
   logic [DATA_W-1:0]   sh_rd;
   logic [DATA_W-1:0]   rd_msk;
   logic [DATA_W-1:0]   ctrl_rd;

   assign is_data = (addr < NREG_A);
   assign is_ctrl = (addr == CTRL_ADDR);
   assign idx     = addr[IDX_W-1:0];
   assign sh_rd   = shadow_q[idx*DATA_W +: DATA_W];
   assign rd_msk  = RD_MASK[idx*DATA_W +: DATA_W];

`ifdef REG_PARITY_EN
   function automatic logic [REG_COUNT-1:0] par_of(
      input logic [TOT_W-1:0] v
   );
      logic [REG_COUNT-1:0] r;
      for (int i = 0; i < REG_COUNT; i++) begin
         r[i] = ^v[i*DATA_W +: DATA_W];
      end
      return r;
   endfunction

   localparam logic [REG_COUNT-1:0] PAR_RST = par_of(RST_VAL);

   logic [REG_COUNT-1:0] par_q, par_d;
   logic [REG_COUNT-1:0] par_bad;
   logic                 par_err_q, par_err_d;

   // Even parity: stored bit equals XOR of the data, so any
   // single-bit upset in the shadow copy shows up as a mismatch.
   always_comb begin
      par_bad = '0;
      for (int i = 0; i < REG_COUNT; i++) begin
         par_bad[i] = par_q[i] ^ (^shadow_q[i*DATA_W +: DATA_W]);
      end
   end
`endif

   always_comb begin
      ctrl_rd    = '0;
      ctrl_rd[1] = lock_q;
`ifdef REG_PARITY_EN
      ctrl_rd[2] = par_err_q;
`endif
   end

   always_comb begin
      state_d  = state_q;
      ack_d    = ack_q;
      dout_d   = dout_q;
      err_d    = err_q;
      commit_d = 1'b0;
      lock_d   = lock_q;
      shadow_d = shadow_q;
      active_d = active_q;
`ifdef REG_PARITY_EN
      par_d     = par_q;
      par_err_d = par_err_q | (|par_bad);
`endif
      unique case (state_q)
         IDLE: begin
            if (req) begin
               state_d = RESP;
               ack_d   = 1'b1;
               dout_d  = '0;
               err_d   = 1'b0;
               unique case (1'b1)
                  is_data: begin
                     if (wre) begin
                        if (lock_q) begin
                           err_d = 1'b1;
                        end else begin
                           shadow_d[idx*DATA_W +: DATA_W] = din;
                           if (!SHADOW_MASK[idx]) begin
                              active_d[idx*DATA_W +: DATA_W] = din;
                           end
`ifdef REG_PARITY_EN
                           par_d[idx] = ^din;
`endif
                        end
                     end else begin
                        dout_d = sh_rd & rd_msk;
`ifdef REG_PARITY_EN
                        err_d  = par_bad[idx];
`endif
                     end
                  end
                  is_ctrl: begin
                     if (wre) begin
                        // Lock and commit land on the same edge; commit
                        // copies the shadow state as it was before it.
                        lock_d = din[1];
                        if (din[0]) begin
                           commit_d = 1'b1;
                           for (int i = 0; i < REG_COUNT; i++) begin
                              if (SHADOW_MASK[i]) begin
                                 active_d[i*DATA_W +: DATA_W] =
                                    shadow_q[i*DATA_W +: DATA_W];
                              end
                           end
                        end
                     end else begin
                        dout_d = ctrl_rd;
                     end
                  end
                  default: begin
                     err_d = 1'b1;
                  end
               endcase
            end
         end
         RESP: begin
            if (!req) begin
               state_d = IDLE;
               ack_d   = 1'b0;
               dout_d  = '0;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         ack_q     <= 1'b0;
         dout_q    <= '0;
         err_q     <= 1'b0;
         commit_q  <= 1'b0;
         lock_q    <= 1'b0;
         shadow_q  <= RST_VAL;
         active_q  <= RST_VAL;
`ifdef REG_PARITY_EN
         par_q     <= PAR_RST;
         par_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         ack_q     <= ack_d;
         dout_q    <= dout_d;
         err_q     <= err_d;
         commit_q  <= commit_d;
         lock_q    <= lock_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
`ifdef REG_PARITY_EN
         par_q     <= par_d;
         par_err_q <= par_err_d;
`endif
      end
   end

   assign ack      = ack_q;
   assign dout     = dout_q;
   assign err      = err_q;
   assign regs_q   = active_q;
   assign commit_p = commit_q;

endmodule

// File: tb/tb_regbank_shadow.sv
// tb_regbank_shadow: random and directed accesses against a
// register-file model; outputs compared on every falling edge.
module tb_regbank_shadow;

   localparam logic [127:0] RSTV = 128'hA500_0000_0000_0000_0000_0000_0000_005A;
   localparam logic [127:0] RDM  = {{15{8'hFF}}, 8'h0F};
   localparam logic [15:0]  SMSK = 16'h2224;
   localparam logic [7:0]   CTRL = 8'hFF;

   logic         sclk = 1'b0;
   logic         rstn;
   logic         req, wre;
   logic [7:0]   addr, din;
   logic         ack, err, commit_p;
   logic [7:0]   dout;
   logic [127:0] regs_q;

   regbank_shadow #(
      .REG_COUNT(16), .DATA_W(8), .ADDR_W(8),
      .RST_VAL(RSTV), .RD_MASK(RDM), .SHADOW_MASK(SMSK),
      .CTRL_ADDR(CTRL)
   ) dut (
      .sclk(sclk), .rstn(rstn), .req(req), .wre(wre),
      .addr(addr), .din(din), .ack(ack), .dout(dout),
      .err(err), .regs_q(regs_q), .commit_p(commit_p)
   );

   always #5 sclk = ~sclk;

   int n_cmp = 0;
   int n_bad = 0;
   logic chk_en = 1'b0;

   logic [7:0] m_sh [16];
   logic [7:0] m_act [16];
   logic       m_bad [16];
   logic       m_lock, m_perr;
   logic       exp_ack, exp_err, exp_commit;
   logic [7:0] exp_dout;

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic logic [127:0] m_regs();
      logic [127:0] v;
      for (int i = 0; i < 16; i++) v[i*8 +: 8] = m_act[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_sh[i]  = RSTV[i*8 +: 8];
         m_act[i] = RSTV[i*8 +: 8];
         m_bad[i] = 1'b0;
      end
      m_lock = 0; m_perr = 0;
      exp_ack = 0; exp_err = 0; exp_commit = 0; exp_dout = 0;
   endtask

   // Apply one accepted access to the model and set the response.
   task automatic model_access(input logic w, input logic [7:0] a,
                               input logic [7:0] d);
      int ai;
      ai = int'(a);
      exp_ack = 1; exp_dout = 0; exp_err = 0;
      if (ai < 16) begin
         if (w) begin
            if (m_lock) exp_err = 1;
            else begin
               m_sh[ai] = d;
               m_bad[ai] = 0;
               if (!SMSK[ai]) m_act[ai] = d;
            end
         end else begin
            exp_dout = m_sh[ai] & RDM[ai*8 +: 8];
            exp_err  = m_bad[ai];
         end
      end else if (a == CTRL) begin
         if (w) begin
            if (d[0]) begin
               exp_commit = 1;
               for (int i = 0; i < 16; i++)
                  if (SMSK[i]) m_act[i] = m_sh[i];
            end
            m_lock = d[1];
         end else begin
            exp_dout = {5'b0, m_perr, m_lock, 1'b0};
         end
      end else begin
         exp_err = 1;
      end
   endtask

   always @(negedge sclk) begin
      if (chk_en) begin
         chk("ack", ack, exp_ack);
         chk("dout", dout, exp_dout);
         chk("err", err, exp_err);
         chk("commit_p", commit_p, exp_commit);
         chk("regs_q", regs_q, m_regs());
      end
   end

   task automatic access(input logic w, input logic [7:0] a,
                         input logic [7:0] d, input int hold,
                         output logic [7:0] rd, output logic re,
                         output logic cp);
      @(negedge sclk);
      req = 1; wre = w; addr = a; din = d;
      @(posedge sclk);
      exp_commit = 0;
      model_access(w, a, d);
      @(negedge sclk);
      cp = commit_p;
      for (int k = 0; k < hold; k++) begin
         @(posedge sclk);
         exp_commit = 0;
         @(negedge sclk);
      end
      rd = dout; re = err;
      req = 0;
      @(posedge sclk);
      exp_commit = 0; exp_ack = 0; exp_dout = 0; exp_err = 0;
   endtask

   logic [7:0] rd, a, d;
   logic       re, cp, w, fb;
   int         r, h;

   initial begin
      rstn = 0; req = 0; wre = 0; addr = 0; din = 0;
      model_reset();
      repeat (3) @(posedge sclk);
      @(negedge sclk);
      rstn = 1;
      @(posedge sclk);
      chk_en = 1;
      #1;
      chk("rst_reg0", regs_q[7:0], 8'h5A);
      chk("rst_ack", ack, 1'b0);

      access(0, CTRL, 8'h00, 0, rd, re, cp);
      chk("ctrl_rst", rd, 8'h00);

      access(1, 8'd3, 8'hC3, 2, rd, re, cp);
      chk("wr3_act", regs_q[31:24], 8'hC3);
      access(0, 8'd3, 8'h00, 0, rd, re, cp);
      chk("rd3", rd, 8'hC3);
      chk("rd3_err", re, 1'b0);

      access(1, 8'd2, 8'h7E, 0, rd, re, cp);
      chk("wr2_pend", regs_q[23:16], 8'h00);
      access(0, 8'd2, 8'h00, 1, rd, re, cp);
      chk("rd2_pend", rd, 8'h7E);
      access(1, CTRL, 8'h01, 0, rd, re, cp);
      chk("commit_pulse", cp, 1'b1);
      chk("wr2_commit", regs_q[23:16], 8'h7E);

      access(1, CTRL, 8'h03, 0, rd, re, cp);
      access(1, 8'd3, 8'h11, 0, rd, re, cp);
      chk("lock_err", re, 1'b1);
      chk("lock_keep", regs_q[31:24], 8'hC3);
      access(0, CTRL, 8'h00, 0, rd, re, cp);
      chk("ctrl_lock", rd, 8'h02);
      access(1, CTRL, 8'h00, 0, rd, re, cp);
      access(1, 8'd3, 8'h11, 0, rd, re, cp);
      chk("unlock_err", re, 1'b0);
      chk("unlock_wr", regs_q[31:24], 8'h11);

      access(0, 8'd16, 8'h00, 0, rd, re, cp);
      chk("bad16_dout", rd, 8'h00);
      chk("bad16_err", re, 1'b1);
      access(0, 8'hF0, 8'h00, 0, rd, re, cp);
      chk("badF0_err", re, 1'b1);

      access(1, 8'd0, 8'hFF, 0, rd, re, cp);
      access(0, 8'd0, 8'h00, 0, rd, re, cp);
      chk("rdmask", rd, 8'h0F);
      chk("rdmask_act", regs_q[7:0], 8'hFF);

      for (int k = 0; k < 300; k++) begin
         r = int'($urandom_range(0, 99));
         if (r < 70)      a = 8'($urandom_range(0, 15));
         else if (r < 85) a = CTRL;
         else             a = 8'($urandom_range(16, 254));
         w = 1'($urandom_range(0, 1));
         d = 8'($urandom);
         h = int'($urandom_range(0, 2));
         access(w, a, d, h, rd, re, cp);
         repeat ($urandom_range(0, 2)) @(posedge sclk);
      end

`ifdef REG_PARITY_EN
      access(1, CTRL, 8'h00, 0, rd, re, cp);
      @(negedge sclk);
      fb = dut.shadow_q[3];
      force dut.shadow_q[3] = ~fb;
      m_sh[0][3] = ~fb;
      m_bad[0] = 1;
      @(posedge sclk);
      release dut.shadow_q[3];
      m_perr = 1;
      access(0, CTRL, 8'h00, 0, rd, re, cp);
      chk("par_ctrl", rd, 8'h04);
      access(0, 8'd0, 8'h00, 0, rd, re, cp);
      chk("par_rd_err", re, 1'b1);
`endif

      // Reset pulsed while the response is being held.
      @(negedge sclk);
      req = 1; wre = 0; addr = 8'd3;
      @(posedge sclk);
      model_access(0, 8'd3, 8'h00);
      @(negedge sclk);
      #2;
      chk_en = 0;
      rstn = 0;
      #1;
      chk("rst_async_ack", ack, 1'b0);
      chk("rst_async_regs", regs_q, RSTV);
      chk("rst_async_dout", dout, 8'h00);
      req = 0;
      model_reset();
      @(negedge sclk);
      rstn = 1;
      @(posedge sclk);
      chk_en = 1;
      access(0, 8'd3, 8'h00, 0, rd, re, cp);
      chk("rst_reg3", rd, 8'h00);
      access(0, CTRL, 8'h00, 0, rd, re, cp);
      chk("rst_ctrl", rd, 8'h00);

      repeat (2) @(posedge sclk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
